// File: rtl/p_hardisc.sv
// ============================================================================
// Module : p_hardisc
// Shared core types and widths used by the BOP sequencing controller.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package p_hardisc;

    localparam int BOP_WIDTH = 32;

    typedef enum logic [1:0] {
        BOPC_RUN   = 2'd0,
        BOPC_FLUSH = 2'd1,
        BOPC_HOLD  = 2'd2
    } bop_ctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/bop_ctrl.sv
// ============================================================================
// Module : bop_ctrl
// Push/pop/flush sequencing for the buffer of predictions; optional shadow
// occupancy check enabled by BOP_CONSISTENCY_CHECK_EN.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module bop_ctrl
    import p_hardisc::*;
#(
    parameter int SIZE        = 2,
    parameter int HOLD_CYCLES = 2
) (
    input  logic                 s_clk_i,
    input  logic                 s_rst_i,
    input  logic                 s_flush_i,
    input  logic                 s_pred_valid_i,
    input  logic [BOP_WIDTH-1:0] s_pred_addr_i,
    output logic                 s_pred_stall_o,
    input  logic                 s_toc_i,
    input  logic [BOP_WIDTH-1:0] s_toc_addr_i,
    output logic                 s_mispredict_o,
    output logic [BOP_WIDTH-1:0] s_redirect_addr_o,
    output logic                 s_err_o,
    output logic                 s_bop_push_o,
    output logic                 s_bop_pop_o,
    output logic                 s_bop_flush_o,
    output logic [BOP_WIDTH-1:0] s_bop_data_o,
    input  logic [BOP_WIDTH-1:0] s_bop_data_i,
    input  logic                 s_bop_ready_i,
    input  logic                 s_bop_full_i
);

    localparam int HOLD_W = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;

    bop_ctrl_state_t      state_q, state_d;
    logic [HOLD_W-1:0]    hold_q, hold_d;
    logic                 mispredict_q, mispredict_d;
    logic [BOP_WIDTH-1:0] redirect_q, redirect_d;
    logic                 err_q, err_d;

    logic w_run, w_pop, w_push, w_mismatch, w_toc_empty, w_cons_err;

    always_comb begin
        w_run       = (state_q == BOPC_RUN) & ~s_rst_i;
        w_pop       = w_run & s_toc_i & s_bop_ready_i & ~s_flush_i;
        w_mismatch  = w_pop & (s_bop_data_i != s_toc_addr_i);
        w_toc_empty = w_run & s_toc_i & ~s_bop_ready_i & ~s_flush_i;
        // A mismatching pop flushes the BOP next cycle, so the new entry would be lost anyway.
        w_push      = w_run & s_pred_valid_i & ~s_flush_i
                    & (~s_bop_full_i | w_pop) & ~w_mismatch;
    end

    assign s_bop_pop_o       = w_pop;
    assign s_bop_push_o      = w_push;
    assign s_pred_stall_o    = s_pred_valid_i & ~w_push & ~s_rst_i;
    assign s_bop_flush_o     = s_rst_i | s_flush_i | (state_q == BOPC_FLUSH);
    assign s_bop_data_o      = s_pred_addr_i;
    assign s_mispredict_o    = mispredict_q;
    assign s_redirect_addr_o = redirect_q;
    assign s_err_o           = err_q;

`ifdef BOP_CONSISTENCY_CHECK_EN
    localparam int OCC_W = $clog2(SIZE + 1);

    logic [OCC_W-1:0] occ_q;

    always_ff @(posedge s_clk_i) begin
        if (s_bop_flush_o) begin
            occ_q <= '0;
        end else if (w_push & ~w_pop) begin
            occ_q <= occ_q + 1'b1;
        end else if (w_pop & ~w_push) begin
            occ_q <= occ_q - 1'b1;
        end
    end

    assign w_cons_err = w_run & (((occ_q == OCC_W'(SIZE)) != s_bop_full_i)
                               | ((occ_q != '0) != s_bop_ready_i));
`else
    assign w_cons_err = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        hold_d     = hold_q;
        redirect_d = redirect_q;
        err_d      = err_q | w_toc_empty | w_cons_err;
        // External flush takes the same exit as the FLUSH state: refill window, no mispredict.
        if (s_flush_i || state_q == BOPC_FLUSH) begin
            hold_d  = HOLD_W'(HOLD_CYCLES);
            state_d = (HOLD_CYCLES == 0) ? BOPC_RUN : BOPC_HOLD;
        end else begin
            case (state_q)
                BOPC_RUN: begin
                    if (w_mismatch || w_toc_empty) begin
                        redirect_d = s_toc_addr_i;
                        state_d    = BOPC_FLUSH;
                    end
                end
                BOPC_HOLD: begin
                    hold_d = hold_q - 1'b1;
                    if (hold_q <= HOLD_W'(1)) begin
                        state_d = BOPC_RUN;
                    end
                end
                default: state_d = BOPC_RUN;
            endcase
        end
        mispredict_d = (state_d == BOPC_FLUSH);
    end

    always_ff @(posedge s_clk_i) begin
        if (s_rst_i) begin
            state_q      <= BOPC_RUN;
            hold_q       <= '0;
            mispredict_q <= 1'b0;
            redirect_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            mispredict_q <= mispredict_d;
            redirect_q   <= redirect_d;
            err_q        <= err_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_bop_ctrl.sv
// ============================================================================
// Module : tb_bop_ctrl
// Randomised scoreboard bench for bop_ctrl against a cycle-count reference model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_bop_ctrl;
    import p_hardisc::*;

    localparam int SIZE = 2;
    localparam int HOLD = 2;
    localparam int W    = BOP_WIDTH;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1, flush = 1'b0, pv = 1'b0, toc = 1'b0;
    logic [W-1:0] paddr = '0, taddr = '0, bdata = '0;
    logic         bready = 1'b0, bfull = 1'b0;

    logic         stall_o, misp_o, err_o, push_o, pop_o, bflush_o;
    logic [W-1:0] redir_o, bdata_o;

    bop_ctrl #(.SIZE(SIZE), .HOLD_CYCLES(HOLD)) dut (
        .s_clk_i           (clk),
        .s_rst_i           (rst),
        .s_flush_i         (flush),
        .s_pred_valid_i    (pv),
        .s_pred_addr_i     (paddr),
        .s_pred_stall_o    (stall_o),
        .s_toc_i           (toc),
        .s_toc_addr_i      (taddr),
        .s_mispredict_o    (misp_o),
        .s_redirect_addr_o (redir_o),
        .s_err_o           (err_o),
        .s_bop_push_o      (push_o),
        .s_bop_pop_o       (pop_o),
        .s_bop_flush_o     (bflush_o),
        .s_bop_data_o      (bdata_o),
        .s_bop_data_i      (bdata),
        .s_bop_ready_i     (bready),
        .s_bop_full_i      (bfull)
    );

    typedef struct packed {
        logic         push, pop, stall, bflush, misp, err;
        logic [W-1:0] redir, data;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_pass = 0;

    // Reference model: the BOP as a queue, blocking expressed as cycle numbers.
    logic [W-1:0] m_bop[$];
    longint       cyc       = 0;
    longint       run_from  = 0;
    longint       flush_cyc = -1;
    logic         m_err     = 1'b0;
    logic [W-1:0] m_redir   = '0;
    bit           inj_full  = 1'b0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act !== exp)
            $display("FAIL %s cycle-ish t=%0t: got %h expected %h", name, $time, act, exp);
        else
            n_pass++;
    endtask

    task automatic step(input bit r, input bit f, input bit v, input logic [W-1:0] pa,
                        input bit t, input logic [W-1:0] ta);
        bit   running, m_pop, m_push, mism, etoc, bfl, full, ready, cons;
        exp_t e;
        @(posedge clk);
        #1;
        full  = inj_full || (m_bop.size() == SIZE);
        ready = (m_bop.size() != 0);
        rst = r; flush = f; pv = v; paddr = pa; toc = t; taddr = ta;
        bfull = full; bready = ready; bdata = ready ? m_bop[0] : '0;

        running = !r && (cyc >= run_from) && (cyc != flush_cyc);
        m_pop   = running && t && ready && !f;
        mism    = m_pop && (m_bop[0] != ta);
        etoc    = running && t && !ready && !f;
        m_push  = running && v && !f && (!full || m_pop) && !mism;
        bfl     = r || f || (cyc == flush_cyc);

        e.push   = m_push;
        e.pop    = m_pop;
        e.stall  = v && !m_push && !r;
        e.bflush = bfl;
        e.misp   = (cyc == flush_cyc);
        e.err    = m_err;
        e.redir  = m_redir;
        e.data   = pa;
        exp_q.push_back(e);

        cons = 1'b0;
`ifdef BOP_CONSISTENCY_CHECK_EN
        cons = running && (((m_bop.size() == SIZE) != full) || ((m_bop.size() != 0) != ready));
`endif
        if (r) begin
            m_bop.delete();
            run_from = cyc + 1; flush_cyc = -1; m_err = 1'b0; m_redir = '0;
        end else begin
            m_err = m_err | etoc | cons;
            if (f) begin
                run_from = cyc + 1 + HOLD;
            end else if (cyc == flush_cyc) begin
                run_from = cyc + 1 + HOLD;
            end else if (mism || etoc) begin
                flush_cyc = cyc + 1;
                run_from  = cyc + 2 + HOLD;
                m_redir   = ta;
            end
            if (bfl) m_bop.delete();
            else begin
                if (m_pop)  void'(m_bop.pop_front());
                if (m_push) m_bop.push_back(pa);
            end
        end
        cyc++;
    endtask

    exp_t mon_e;
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("push",     W'(push_o),   W'(mon_e.push));
            chk("pop",      W'(pop_o),    W'(mon_e.pop));
            chk("stall",    W'(stall_o),  W'(mon_e.stall));
            chk("bop_flush",W'(bflush_o), W'(mon_e.bflush));
            chk("mispred",  W'(misp_o),   W'(mon_e.misp));
            chk("err",      W'(err_o),    W'(mon_e.err));
            chk("redirect", redir_o,      mon_e.redir);
            chk("bop_data", bdata_o,      mon_e.data);
        end
    end

    function automatic logic [W-1:0] head_or_rand();
        if (m_bop.size() != 0 && ($urandom % 4) != 0) return m_bop[0];
        return W'($urandom);
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        step(1, 0, 0, '0, 0, '0);
        // fill, stall on full, simultaneous pop+push on full
        step(0, 0, 1, 32'h100, 0, '0);
        step(0, 0, 1, 32'h200, 0, '0);
        step(0, 0, 1, 32'h300, 0, '0);
        step(0, 0, 1, 32'h300, 1, 32'h100);
        // mismatch on pop, then flush/hold window with fetch pressing
        step(0, 0, 0, '0, 1, 32'h204);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 32'h400 + W'(i), 0, '0);
        // external flush with mismatching pop and pred in the same cycle
        step(0, 1, 1, 32'h500, 1, 32'hDEAD);
        for (int i = 0; i < 4; i++) step(0, 0, 0, '0, 0, '0);
        // toc on empty BOP
        step(1, 0, 0, '0, 0, '0);
        step(0, 0, 0, '0, 1, 32'h555);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 32'h600 + W'(i), 0, '0);
        // occupancy 1 but BOP claims full
        step(1, 0, 0, '0, 0, '0);
        step(0, 0, 1, 32'h700, 0, '0);
        inj_full = 1'b1;
        step(0, 0, 0, '0, 0, '0);
        inj_full = 1'b0;
        for (int i = 0; i < 3; i++) step(0, 0, 0, '0, 0, '0);
        // randomised traffic
        for (int i = 0; i < 3000; i++) begin
            bit r, f, v, t;
            logic [W-1:0] pa, ta;
            r  = ($urandom % 200) == 0;
            f  = ($urandom % 25) == 0;
            v  = ($urandom % 2) == 0;
            t  = ($urandom % 3) == 0;
            pa = W'($urandom);
            ta = head_or_rand();
            inj_full = ($urandom % 150) == 0;
            step(r, f, v, pa, t, ta);
        end
        inj_full = 1'b0;
        repeat (3) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_chk++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
